// File: rtl/upower_run_ctrl.sv
// -----------------------------------------------------------------------------
// upower_run_ctrl
//
// Run controller for the uPower core. It decides in which cycles the core
// clock enable is asserted, counts the enabled cycles, and records why the
// last run stopped.
//
// Parameters
//   CNT_W     width of the cycle limit and cycle counter (4..32)
//   STEP_LEN  core cycles executed per accepted step pulse (1..255)
//
// Ports
//   clock        single clock, all state changes on its rising edge
//   reset        synchronous active-high reset
//   start        one-cycle pulse launching a run (mode/max_cycles sampled)
//   mode         00 run-N, 01 free-run, 10 single-step, 11 reserved
//   max_cycles   cycle limit for run-N and single-step
//   step         one-cycle pulse advancing the core in single-step mode
//   halt_req     core retired a halt instruction (sampled while enabled)
//   abort        forces the run to stop
//   core_en      registered clock enable to the core
//   busy         high outside IDLE and DONE
//   done         high in DONE
//   cycle_count  enabled core cycles in the current or last run (saturating)
//   stop_reason  00 none, 01 limit, 10 halt, 11 abort
// -----------------------------------------------------------------------------
module upower_run_ctrl #(
  parameter int CNT_W    = 16,
  parameter int STEP_LEN = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [CNT_W-1:0] max_cycles,
  input  logic             step,
  input  logic             halt_req,
  input  logic             abort,
  output logic             core_en,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] cycle_count,
  output logic [1:0]       stop_reason
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_RUN       = 3'd1,
    S_STEP_WAIT = 3'd2,
    S_STEP_EXEC = 3'd3,
    S_DONE      = 3'd4
  } state_t;

  localparam logic [1:0] MODE_RUN_N = 2'b00;
  localparam logic [1:0] MODE_FREE  = 2'b01;
  localparam logic [1:0] MODE_STEP  = 2'b10;
  localparam logic [1:0] MODE_RSVD  = 2'b11;

  localparam logic [1:0] RSN_NONE  = 2'b00;
  localparam logic [1:0] RSN_LIMIT = 2'b01;
  localparam logic [1:0] RSN_HALT  = 2'b10;
  localparam logic [1:0] RSN_ABORT = 2'b11;

  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [7:0]       STEP_LAST = 8'(STEP_LEN - 1);

  state_t           state_q, state_d;
  logic [1:0]       mode_q, mode_d;
  logic [CNT_W-1:0] max_q, max_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [1:0]       reason_q, reason_d;
  logic [7:0]       step_cnt_q, step_cnt_d;
  logic             core_en_q, core_en_d;

  logic             limit_hit;

  // The limit fires in the enabled cycle that brings the count up to
  // max_cycles. A zero limit never reaches RUN/STEP_EXEC in the limited
  // modes, so max_q-1 cannot underflow when it matters.
  assign limit_hit = core_en_q && (mode_q != MODE_FREE) &&
                     (count_q == (max_q - CNT_ONE));

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    max_d      = max_q;
    reason_d   = reason_q;
    step_cnt_d = step_cnt_q;
    count_d    = count_q;

    // Every enabled cycle is counted, including the one that stops the run.
    if (core_en_q && (count_q != CNT_MAX)) begin
      count_d = count_q + CNT_ONE;
    end

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start && (mode != MODE_RSVD)) begin
          mode_d     = mode;
          max_d      = max_cycles;
          count_d    = '0;
          reason_d   = RSN_NONE;
          step_cnt_d = '0;
          if ((mode != MODE_FREE) && (max_cycles == '0)) begin
            state_d  = S_DONE;
            reason_d = RSN_LIMIT;
          end else if (mode == MODE_STEP) begin
            state_d = S_STEP_WAIT;
          end else begin
            state_d = S_RUN;
          end
        end
      end

      S_RUN: begin
        if (abort) begin
          state_d  = S_DONE;
          reason_d = RSN_ABORT;
        end else if (halt_req) begin
          state_d  = S_DONE;
          reason_d = RSN_HALT;
        end else if (limit_hit) begin
          state_d  = S_DONE;
          reason_d = RSN_LIMIT;
        end
      end

      S_STEP_WAIT: begin
        if (abort) begin
          state_d  = S_DONE;
          reason_d = RSN_ABORT;
        end else if (step) begin
          state_d    = S_STEP_EXEC;
          step_cnt_d = '0;
        end
      end

      S_STEP_EXEC: begin
        // step is deliberately not looked at here: pulses during a burst
        // are dropped rather than queued.
        if (abort) begin
          state_d  = S_DONE;
          reason_d = RSN_ABORT;
        end else if (halt_req) begin
          state_d  = S_DONE;
          reason_d = RSN_HALT;
        end else if (limit_hit) begin
          state_d  = S_DONE;
          reason_d = RSN_LIMIT;
        end else if (step_cnt_q == STEP_LAST) begin
          state_d = S_STEP_WAIT;
        end else begin
          step_cnt_d = step_cnt_q + 8'd1;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // core_en is registered from the next state so it lines up exactly with
    // the RUN and STEP_EXEC cycles.
    core_en_d = (state_d == S_RUN) || (state_d == S_STEP_EXEC);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      mode_q     <= MODE_RUN_N;
      max_q      <= '0;
      count_q    <= '0;
      reason_q   <= RSN_NONE;
      step_cnt_q <= '0;
      core_en_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      max_q      <= max_d;
      count_q    <= count_d;
      reason_q   <= reason_d;
      step_cnt_q <= step_cnt_d;
      core_en_q  <= core_en_d;
    end
  end

  assign core_en     = core_en_q;
  assign busy        = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done        = (state_q == S_DONE);
  assign cycle_count = count_q;
  assign stop_reason = reason_q;

endmodule

// File: tb/tb_upower_run_ctrl.sv
// -----------------------------------------------------------------------------
// tb_upower_run_ctrl
//
// Self-checking bench for upower_run_ctrl. Two instances share the inputs:
// dut_a (CNT_W=16, STEP_LEN=2) for the main scenarios and dut_b (CNT_W=4)
// for counter saturation. Expected results come from a transaction-level
// model: the run length is the earliest of limit / halt / abort, the reason
// follows abort > halt > limit, and single-step bursts are min(2, remaining).
// -----------------------------------------------------------------------------
module tb_upower_run_ctrl;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  mode = 2'b00;
  logic [15:0] max_cycles = 16'd0;
  logic        step = 1'b0;
  logic        halt_req = 1'b0;
  logic        abort = 1'b0;

  logic        a_core_en, a_busy, a_done;
  logic [15:0] a_count;
  logic [1:0]  a_reason;
  logic        b_core_en, b_busy, b_done;
  logic [3:0]  b_count;
  logic [1:0]  b_reason;
  logic [3:0]  max_b;

  logic        use_b = 1'b0;
  logic        o_core_en, o_busy, o_done;
  logic [15:0] o_count;
  logic [1:0]  o_reason;

  int vectors = 0;
  int miscompares = 0;

  assign max_b = max_cycles[3:0];

  assign o_core_en = use_b ? b_core_en : a_core_en;
  assign o_busy    = use_b ? b_busy    : a_busy;
  assign o_done    = use_b ? b_done    : a_done;
  assign o_count   = use_b ? {12'd0, b_count} : a_count;
  assign o_reason  = use_b ? b_reason  : a_reason;

  upower_run_ctrl #(.CNT_W(16), .STEP_LEN(2)) dut_a (
    .clock(clock), .reset(reset), .start(start), .mode(mode),
    .max_cycles(max_cycles), .step(step), .halt_req(halt_req), .abort(abort),
    .core_en(a_core_en), .busy(a_busy), .done(a_done),
    .cycle_count(a_count), .stop_reason(a_reason)
  );

  upower_run_ctrl #(.CNT_W(4), .STEP_LEN(1)) dut_b (
    .clock(clock), .reset(reset), .start(start), .mode(mode),
    .max_cycles(max_b), .step(step), .halt_req(halt_req), .abort(abort),
    .core_en(b_core_en), .busy(b_busy), .done(b_done),
    .cycle_count(b_count), .stop_reason(b_reason)
  );

  always #5 clock = ~clock;

  // Outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; start = 1'b0; step = 1'b0; halt_req = 1'b0; abort = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    vectors++;
    if ({o_core_en, o_busy, o_done, o_count, o_reason} !== 21'd0) begin
      miscompares++;
      $display("FAIL reset_state: got en=%0b busy=%0b done=%0b cnt=%0d rsn=%0d, want all 0",
               o_core_en, o_busy, o_done, o_count, o_reason);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    vectors++;
    if (o_busy !== 1'b0 || o_done !== 1'b0 || o_reason !== 2'd0) begin
      miscompares++;
      $display("FAIL abort_in_idle: got busy=%0b done=%0b rsn=%0d, want 0 0 0",
               o_busy, o_done, o_reason);
    end
    $display("reset: en=%0b busy=%0b done=%0b cnt=%0d rsn=%0d",
             o_core_en, o_busy, o_done, o_count, o_reason);
  endtask

  // One run-N / free-run transaction. h and a are the 1-based enabled
  // cycle indices at which halt_req / abort are raised (0 = never).
  task automatic run_scenario(input int md, input int mx, input int h,
                              input int a, input int w);
    int inf, n, exp_rsn, exp_cnt, k, sat;
    inf = 1 << 30;
    sat = (1 << w) - 1;
    n = inf;
    if (md == 0) n = mx;
    if (h != 0 && h < n) n = h;
    if (a != 0 && a < n) n = a;
    if (a != 0 && a == n)      exp_rsn = 3;
    else if (h != 0 && h == n) exp_rsn = 2;
    else                       exp_rsn = 1;
    exp_cnt = (n > sat) ? sat : n;

    start = 1'b1; mode = 2'(md); max_cycles = 16'(mx);
    tick();
    start = 1'b0;
    // Scramble the inputs after sampling: the run must use latched values.
    mode = 2'($urandom_range(0, 1)); max_cycles = 16'($urandom);

    k = 0;
    while (o_core_en === 1'b1 && k < 200) begin
      k++;
      vectors++;
      if (o_busy !== 1'b1 || o_done !== 1'b0) begin
        miscompares++;
        $display("FAIL busy_in_run: cycle %0d got busy=%0b done=%0b, want 1 0",
                 k, o_busy, o_done);
      end
      halt_req = (k == h);
      abort    = (k == a);
      tick();
    end
    halt_req = 1'b0; abort = 1'b0;

    vectors++;
    if (k !== n || o_done !== 1'b1 || o_count !== 16'(exp_cnt) ||
        o_reason !== 2'(exp_rsn)) begin
      miscompares++;
      $display("FAIL run_result: mode=%0d max=%0d h=%0d a=%0d got cycles=%0d done=%0b cnt=%0d rsn=%0d, want cycles=%0d done=1 cnt=%0d rsn=%0d",
               md, mx, h, a, k, o_done, o_count, o_reason, n, exp_cnt, exp_rsn);
    end
    tick(); tick();
    vectors++;
    if (o_done !== 1'b1 || o_count !== 16'(exp_cnt) || o_reason !== 2'(exp_rsn)) begin
      miscompares++;
      $display("FAIL done_hold: got done=%0b cnt=%0d rsn=%0d, want 1 %0d %0d",
               o_done, o_count, o_reason, exp_cnt, exp_rsn);
    end
    $display("run mode=%0d max=%0d halt@%0d abort@%0d -> cycles=%0d cnt=%0d rsn=%0d",
             md, mx, h, a, k, o_count, o_reason);
  endtask

  // Single-step on dut_a (STEP_LEN=2): each accepted pulse runs
  // min(2, remaining) cycles. Spurious steps during a burst and halt_req
  // while waiting must have no effect.
  task automatic test_single_step(input int mx);
    int rem, exp_len, len, guard;
    start = 1'b1; mode = 2'b10; max_cycles = 16'(mx);
    tick();
    start = 1'b0; max_cycles = 16'($urandom);
    rem = mx;
    guard = 0;
    while (rem > 0 && guard < 20) begin
      guard++;
      repeat ($urandom_range(1, 3)) begin
        halt_req = 1'($urandom_range(0, 1));
        tick();
        vectors++;
        if (o_core_en !== 1'b0 || o_busy !== 1'b1 || o_done !== 1'b0) begin
          miscompares++;
          $display("FAIL step_wait: got en=%0b busy=%0b done=%0b, want 0 1 0",
                   o_core_en, o_busy, o_done);
        end
      end
      halt_req = 1'b0;
      step = 1'b1;
      tick();
      step = 1'b0;
      exp_len = (rem < 2) ? rem : 2;
      len = 0;
      while (o_core_en === 1'b1 && len < 10) begin
        len++;
        step = (len == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
        tick();
      end
      step = 1'b0;
      vectors++;
      if (len !== exp_len) begin
        miscompares++;
        $display("FAIL step_burst: got len=%0d, want %0d (remaining %0d)", len, exp_len, rem);
      end
      $display("step burst: len=%0d remaining_before=%0d", len, rem);
      rem -= exp_len;
    end
    vectors++;
    if (o_done !== 1'b1 || o_count !== 16'(mx) || o_reason !== 2'd1) begin
      miscompares++;
      $display("FAIL step_result: got done=%0b cnt=%0d rsn=%0d, want 1 %0d 1",
               o_done, o_count, o_reason, mx);
    end
    step = 1'b1;
    tick();
    step = 1'b0;
    tick();
    vectors++;
    if (o_core_en !== 1'b0 || o_done !== 1'b1 || o_count !== 16'(mx)) begin
      miscompares++;
      $display("FAIL step_after_done: got en=%0b done=%0b cnt=%0d, want 0 1 %0d",
               o_core_en, o_done, o_count, mx);
    end
    $display("single-step max=%0d -> cnt=%0d rsn=%0d", mx, o_count, o_reason);
  endtask

  task automatic test_reset_mid_run();
    start = 1'b1; mode = 2'b01; max_cycles = 16'd0;
    tick();
    start = 1'b0;
    tick();
    vectors++;
    if (o_core_en !== 1'b1 || o_count !== 16'd1) begin
      miscompares++;
      $display("FAIL mid_run_pre: got en=%0b cnt=%0d, want 1 1", o_core_en, o_count);
    end
    reset = 1'b1; start = 1'b1; step = 1'b1; abort = 1'b1; halt_req = 1'b1;
    tick();
    reset = 1'b0; start = 1'b0; step = 1'b0; abort = 1'b0; halt_req = 1'b0;
    vectors++;
    if ({o_core_en, o_busy, o_done, o_count, o_reason} !== 21'd0) begin
      miscompares++;
      $display("FAIL reset_mid_run: got en=%0b busy=%0b done=%0b cnt=%0d rsn=%0d, want all 0",
               o_core_en, o_busy, o_done, o_count, o_reason);
    end
    tick();
    vectors++;
    if (o_core_en !== 1'b0 || o_busy !== 1'b0 || o_done !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_beats_start: got en=%0b busy=%0b done=%0b, want idle",
               o_core_en, o_busy, o_done);
    end
    $display("reset mid-run: en=%0b busy=%0b cnt=%0d", o_core_en, o_busy, o_count);
  endtask

  task automatic test_ignored_inputs();
    int k;
    do_reset();
    // Reserved mode.
    start = 1'b1; mode = 2'b11; max_cycles = 16'd7;
    tick();
    start = 1'b0;
    vectors++;
    if (o_busy !== 1'b0 || o_done !== 1'b0 || o_core_en !== 1'b0) begin
      miscompares++;
      $display("FAIL mode11_start: got busy=%0b done=%0b en=%0b, want 0 0 0",
               o_busy, o_done, o_core_en);
    end
    $display("mode 11 start: busy=%0b done=%0b", o_busy, o_done);
    // Start while busy must not restart or shorten the run.
    start = 1'b1; mode = 2'b00; max_cycles = 16'd6;
    tick();
    start = 1'b0;
    k = 0;
    while (o_core_en === 1'b1 && k < 50) begin
      k++;
      start = (k == 3);
      max_cycles = 16'd2;
      tick();
    end
    start = 1'b0;
    vectors++;
    if (k !== 6 || o_count !== 16'd6 || o_reason !== 2'd1) begin
      miscompares++;
      $display("FAIL start_while_busy: got cycles=%0d cnt=%0d rsn=%0d, want 6 6 1",
               k, o_count, o_reason);
    end
    $display("start while busy: cycles=%0d cnt=%0d", k, o_count);
    // Zero limit in single-step mode.
    start = 1'b1; mode = 2'b10; max_cycles = 16'd0;
    tick();
    start = 1'b0;
    vectors++;
    if (o_done !== 1'b1 || o_core_en !== 1'b0 || o_count !== 16'd0 || o_reason !== 2'd1) begin
      miscompares++;
      $display("FAIL step_zero_limit: got done=%0b en=%0b cnt=%0d rsn=%0d, want 1 0 0 1",
               o_done, o_core_en, o_count, o_reason);
    end
    // Abort while waiting for a step.
    start = 1'b1; mode = 2'b10; max_cycles = 16'd5;
    tick();
    start = 1'b0;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    vectors++;
    if (o_done !== 1'b1 || o_count !== 16'd0 || o_reason !== 2'd3) begin
      miscompares++;
      $display("FAIL abort_step_wait: got done=%0b cnt=%0d rsn=%0d, want 1 0 3",
               o_done, o_count, o_reason);
    end
    $display("abort in step wait: done=%0b rsn=%0d", o_done, o_reason);
  endtask

  task automatic test_directed_runs();
    do_reset();
    run_scenario(0, 5, 0, 0, 16);   // plain limit run
    run_scenario(1, 9, 3, 0, 16);   // halt on 3rd cycle, free-run
    run_scenario(0, 4, 4, 0, 16);   // halt coincides with limit
    run_scenario(0, 4, 4, 4, 16);   // all three coincide
    run_scenario(0, 0, 0, 0, 16);   // zero limit -> immediate DONE
    run_scenario(1, 0, 0, 2, 16);   // free-run ignores zero limit
    run_scenario(0, 1, 0, 0, 16);   // single-cycle run
  endtask

  task automatic test_random_runs();
    int md, mx, h, a;
    repeat (12) begin
      md = $urandom_range(0, 1);
      mx = $urandom_range(1, 20);
      h  = $urandom_range(0, 25);
      a  = $urandom_range(0, 25);
      if (md == 1 && h == 0 && a == 0) a = $urandom_range(1, 25);
      run_scenario(md, mx, h, a, 16);
    end
  endtask

  task automatic test_saturation();
    use_b = 1'b1;
    do_reset();
    run_scenario(1, 0, 0, 21, 4);   // 20 cycles saturate at 15, abort on 21st
    run_scenario(0, 9, 0, 0, 4);
    use_b = 1'b0;
  endtask

  initial begin
    test_reset();
    test_directed_runs();
    test_single_step(3);
    test_single_step($urandom_range(1, 7));
    test_single_step($urandom_range(1, 7));
    test_reset_mid_run();
    test_ignored_inputs();
    test_random_runs();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Hard stop in case a DUT event never arrives.
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit, vectors=%0d miscompares=%0d",
             vectors, miscompares);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/upower_run_ctrl.md
UPOWER_RUN_CTRL -- requirements
Module: upower_run_ctrl

Interface
REQ-001 Parameter CNT_W, default 16: width of cycle limit and cycle counter; legal range 4..32.
REQ-002 Parameter STEP_LEN, default 1: core cycles executed per accepted step pulse; legal range 1..255.
REQ-003 clock  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  one-cycle pulse that launches a run.
REQ-006 mode  input  2  run mode, sampled with start: 00 = run-N, 01 = free-run, 10 = single-step, 11 = reserved.
REQ-007 max_cycles  input  CNT_W  cycle limit, sampled with start.
REQ-008 step  input  1  one-cycle pulse; advances the core in single-step mode.
REQ-009 halt_req  input  1  core halt indication (halt instruction retired).
REQ-010 abort  input  1  forces the run to stop.
REQ-011 core_en  output  1  clock enable to uPower_core; registered.
REQ-012 busy  output  1  high in any state other than IDLE and DONE.
REQ-013 done  output  1  high in state DONE.
REQ-014 cycle_count  output  CNT_W  number of enabled core cycles in the current or last run.
REQ-015 stop_reason  output  2  cause of the last stop: 00 = none, 01 = limit, 10 = halt, 11 = abort.

Function
REQ-016 The block SHALL have the states IDLE, RUN, STEP_WAIT, STEP_EXEC and DONE.
REQ-017 core_en SHALL be 1 exactly in RUN and STEP_EXEC, and 0 in every other state.
REQ-018 In IDLE or DONE, start=1 with mode 00/01 SHALL latch mode and max_cycles, clear cycle_count, set stop_reason=00 and go to RUN next cycle; with mode 10 it SHALL do the same but go to STEP_WAIT.
REQ-019 start with mode 11 SHALL be ignored; start in RUN, STEP_WAIT or STEP_EXEC SHALL be ignored.
REQ-020 start with mode 00 or 10 and max_cycles=0 SHALL go directly to DONE with stop_reason=01, cycle_count=0 and no core_en cycle.
REQ-021 cycle_count SHALL increment by 1 in every cycle core_en=1, saturating at 2^CNT_W-1 (no wrap).
REQ-022 In RUN, mode 00: the cycle in which core_en=1 and cycle_count==max_cycles-1 SHALL be the last enabled cycle; next state DONE, stop_reason=01.
REQ-023 Mode 01 SHALL ignore max_cycles and stop only on halt_req or abort.
REQ-024 halt_req SHALL be sampled only while core_en=1; halt_req=1 SHALL send the FSM to DONE next cycle with stop_reason=10, and that halting cycle SHALL be counted.
REQ-025 abort=1 in RUN, STEP_WAIT or STEP_EXEC SHALL go to DONE next cycle with stop_reason=11; abort in IDLE or DONE SHALL be ignored.
REQ-026 Stop priority, when causes coincide in one cycle: abort > halt > limit.
REQ-027 STEP_WAIT: step=1 SHALL go to STEP_EXEC, which SHALL last min(STEP_LEN, remaining limit) cycles and then return to STEP_WAIT; the limit SHALL apply as in mode 00.
REQ-028 step pulses outside STEP_WAIT, including during STEP_EXEC, SHALL be ignored, not queued.
REQ-029 DONE SHALL hold cycle_count and stop_reason until the next accepted start.

Reset
REQ-030 reset=1 SHALL force IDLE, core_en=0, busy=0, done=0, cycle_count=0, stop_reason=00 on the next edge from any state, including mid-run.
REQ-031 reset SHALL take priority over start, step, abort and halt_req in the same cycle.

Verification
REQ-032 Limit run: mode 00, max_cycles=5, start -> core_en high exactly 5 cycles starting the cycle after start; done=1, cycle_count=5, stop_reason=01.
REQ-033 Halt during free-run: mode 01, halt_req=1 on the 3rd enabled cycle -> DONE, cycle_count=3, stop_reason=10; halt_req and limit hit together in mode 00 -> stop_reason=10.
REQ-034 Single-step: STEP_LEN=2, max_cycles=3, mode 10, three step pulses -> runs of 2 cycles and 1 cycle, third pulse ignored, cycle_count=3, stop_reason=01.
REQ-035 Saturation: CNT_W=4, mode 01, 20 cycles -> cycle_count holds 15; abort then gives stop_reason=11.
REQ-036 Reset mid-run: reset on the 2nd RUN cycle -> next cycle all outputs at reset values; start in the same cycle as reset -> IDLE.
REQ-037 Ignored inputs: start while busy, mode 11 start, max_cycles=0 in mode 00 -> run unaffected, no transition, immediate DONE with stop_reason=01, respectively.
